// File: rtl/fifo_stream_pkg.sv
// Shared types and sizing helpers for the show-ahead FIFO stream reader.
package fifo_stream_pkg;

  // Output buffer occupancy; 2-bit encoding, three legal values.
  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_t;

  // Beat counter width: enough for 0..pkt_len-1, never narrower than one bit.
  function automatic int bcnt_w(input int pkt_len);
    return ($clog2(pkt_len) < 1) ? 1 : $clog2(pkt_len);
  endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry registered output buffer; the head entry is always the oldest word.
module fifo_stream_skid
  import fifo_stream_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head_data,
  output logic              head_valid,
  output occ_t              occ
);

  occ_t              occ_q, occ_d;
  logic [DWIDTH-1:0] head_q, head_d;
  logic [DWIDTH-1:0] tail_q, tail_d;

  // NOTE: both data entries are reset as well, so data_o reads zero after reset
  // instead of stale words; the cost is two DWIDTH-wide reset fan-outs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q  <= OCC_0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // NOTE: every signal gets its hold value first, so no path leaves one
  // unassigned (no latch); blocking '=' is correct inside always_comb.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      OCC_0: begin
        if (push) begin
          head_d = push_data;
          occ_d  = OCC_1;
        end
      end
      OCC_1: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d = push_data;
          occ_d  = OCC_2;
        end else if (pop) begin
          occ_d = OCC_0;
        end
      end
      OCC_2: begin
        // push is never asserted here; the reader gates it on occupancy
        if (pop) begin
          head_d = tail_q;
          occ_d  = OCC_1;
        end
      end
      default: occ_d = OCC_0;
    endcase
  end

  assign head_data  = head_q;
  assign head_valid = (occ_q != OCC_0);
  assign occ        = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO into a valid/ready stream framed into fixed-length
// packets; the pop request depends only on registered state and FIFO flags.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int PKT_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              en_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sop_o,
  output logic              eop_o,
  output logic [CNT_W-1:0]  pkt_cnt_o
);

  localparam int            BW        = bcnt_w(PKT_LEN);
  localparam logic [BW-1:0] BCNT_LAST = BW'(PKT_LEN - 1);

  occ_t          occ;
  logic          pop;
  logic [BW-1:0] bcnt;

  assign fifo_rdreq_o = srst_i & en_i & ~fifo_empty_i & (occ != OCC_2);
  assign pop          = valid_o & ready_i;

  fifo_stream_skid #(
    .DWIDTH(DWIDTH)
  ) u_skid (
    .clk       (clk_i),
    .rst_n     (srst_i),
    .push      (fifo_rdreq_o),
    .push_data (fifo_q_i),
    .pop       (pop),
    .head_data (data_o),
    .head_valid(valid_o),
    .occ       (occ)
  );

  // Framing flags are forced low while reset is applied.
  assign sop_o = srst_i & valid_o & (bcnt == '0);
  assign eop_o = srst_i & valid_o & (bcnt == BCNT_LAST);

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      bcnt      <= '0;
      pkt_cnt_o <= '0;
    end else if (pop) begin
      bcnt <= (bcnt == BCNT_LAST) ? '0 : bcnt + BW'(1);
      if (eop_o) pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: two readers (PKT_LEN 8 and 5) fed from queue-modelled
// FIFOs, compared every cycle against a word/beat-level reference model.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst, en, ready;
  logic [DW-1:0] fifo_q     [2];
  logic          fifo_empty [2];
  logic          rdreq      [2];
  logic [DW-1:0] data       [2];
  logic          valid      [2];
  logic          sop        [2];
  logic          eop        [2];
  logic [CW-1:0] pkt        [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_stream_reader #(
      .DWIDTH (DW),
      .PKT_LEN((g == 0) ? 8 : 5),
      .CNT_W  (CW)
    ) dut (
      .clk_i       (clk),
      .srst_i      (srst),
      .en_i        (en),
      .fifo_q_i    (fifo_q[g]),
      .fifo_empty_i(fifo_empty[g]),
      .fifo_rdreq_o(rdreq[g]),
      .data_o      (data[g]),
      .valid_o     (valid[g]),
      .ready_i     (ready),
      .sop_o       (sop[g]),
      .eop_o       (eop[g]),
      .pkt_cnt_o   (pkt[g])
    );
  end

  // Reference model state: FIFO contents, words popped but not yet delivered,
  // delivered-beat and packet counts since the last reset.
  int            plen [2] = '{8, 5};
  logic [DW-1:0] fq   [2][$];
  logic [DW-1:0] pend [2][$];
  int            beats [2];
  int            pkts  [2];
  int            rdreq_cnt [2];
  int            seg_beats;
  int            wr_left;
  bit            known, after_rst, rand_ready;
  int            total, bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic update_ports();
    for (int i = 0; i < 2; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_q[i]     = (fq[i].size() != 0) ? fq[i][0] : 32'hdead_beef;
    end
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) begin
      fq[0].push_back(base + DW'(k));
      fq[1].push_back(base + DW'(k));
    end
    update_ports();
  endtask

  // One clock: check outputs at the falling edge, then advance the model
  // with what the DUT did at the rising edge.
  task automatic cycle();
    logic          rq [2];
    logic          bt [2];
    logic          vexp;
    logic [DW-1:0] w;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vexp = (pend[i].size() != 0);
      check($sformatf("rdreq%0d", i), rdreq[i],
            srst && en && (fq[i].size() != 0) && (pend[i].size() < 2));
      check($sformatf("sop%0d", i), sop[i], srst && vexp && (beats[i] % plen[i] == 0));
      check($sformatf("eop%0d", i), eop[i],
            srst && vexp && (beats[i] % plen[i] == plen[i] - 1));
      if (known) begin
        check($sformatf("valid%0d", i), valid[i], vexp);
        check($sformatf("pkt%0d", i), pkt[i], CW'(pkts[i] % 65536));
        if (vexp) check($sformatf("data%0d", i), data[i], pend[i][0]);
        else if (after_rst) check($sformatf("data_rst%0d", i), data[i], 0);
      end
      rq[i] = (rdreq[i] === 1'b1);
      bt[i] = (valid[i] === 1'b1) && ready;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!srst) begin
        pend[i].delete();
        beats[i] = 0;
        pkts[i]  = 0;
      end else begin
        if (bt[i] && pend[i].size() != 0) begin
          void'(pend[i].pop_front());
          if (beats[i] % plen[i] == plen[i] - 1) pkts[i]++;
          beats[i]++;
          if (i == 0) seg_beats++;
        end
        if (rq[i] && fq[i].size() != 0) begin
          pend[i].push_back(fq[i].pop_front());
          rdreq_cnt[i]++;
        end
      end
    end
    after_rst = !srst;
    if (!srst) known = 1'b1;
    if (wr_left > 0 && $urandom_range(1, 0) == 1) begin
      w = $urandom;
      fq[0].push_back(w);
      fq[1].push_back(w);
      wr_left--;
    end
    if (rand_ready) ready = $urandom_range(1, 0) == 1;
    update_ports();
  endtask

  function automatic bit busy();
    return (wr_left > 0) || (fq[0].size() != 0) || (fq[1].size() != 0) ||
           (pend[0].size() != 0) || (pend[1].size() != 0);
  endfunction

  task automatic run_idle(input int max_cycles);
    int n = 0;
    while (busy() && n < max_cycles) begin
      cycle();
      n++;
    end
    check("idle_timeout", busy(), 0);
  endtask

  task automatic run_beats(input int target, input int max_cycles);
    int n = 0;
    while (seg_beats < target && n < max_cycles) begin
      cycle();
      n++;
    end
    check("beats_timeout", seg_beats >= target, 1);
  endtask

  initial begin
    total = 0; bad = 0; wr_left = 0; seg_beats = 0;
    known = 1'b0; after_rst = 1'b0; rand_ready = 1'b0;
    beats = '{0, 0}; pkts = '{0, 0}; rdreq_cnt = '{0, 0};
    srst = 1'b0; en = 1'b1; ready = 1'b0;

    // Reset held with a non-empty FIFO; its words 0..15 feed the streaming run.
    load(16, 0);
    repeat (4) cycle();

    // Streaming at full rate.
    srst = 1'b1; ready = 1'b1; seg_beats = 0;
    run_idle(100);
    check("stream_beats", seg_beats, 16);
    check("stream_pkt_l8", pkt[0], 2);
    check("stream_pkt_l5", pkt[1], 3);

    // Backpressure: only two words may be absorbed.
    ready = 1'b0; rdreq_cnt = '{0, 0};
    load(5, 100);
    repeat (6) cycle();
    check("bp_rdreqs", rdreq_cnt[0], 2);
    check("bp_head", data[0], 100);
    ready = 1'b1; seg_beats = 0;
    run_idle(50);
    check("bp_beats", seg_beats, 5);

    // Random traffic from a fresh reset.
    srst = 1'b0; cycle(); srst = 1'b1;
    seg_beats = 0; wr_left = 1000; rand_ready = 1'b1;
    run_idle(20000);
    rand_ready = 1'b0; ready = 1'b1;
    check("rand_beats", seg_beats, 1000);
    check("rand_pkt_l5", pkt[1], 200);
    check("rand_pkt_l8", pkt[0], 125);

    // Enable drop after three beats; drain, then resume.
    load(10, 200); seg_beats = 0;
    run_beats(3, 50);
    en = 1'b0;
    #1 check("en_drop_rdreq", rdreq[0], 0);
    repeat (5) cycle();
    check("en_drained", valid[0], 0);
    en = 1'b1;
    run_idle(50);
    check("en_beats", seg_beats, 10);

    // Reset in the middle of a packet.
    srst = 1'b0; cycle(); srst = 1'b1;
    load(10, 300); seg_beats = 0;
    run_beats(3, 50);
    srst = 1'b0; cycle(); srst = 1'b1;
    check("rst_mid_valid", valid[0], 0);
    check("rst_mid_pkt", pkt[1], 0);
    run_idle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drain engine on the read side of the team's show-ahead FIFO. It pops words from the FIFO read port and presents them on a valid/ready stream. The output stage is a registered two-entry buffer, so `fifo_rdreq_o` never depends combinationally on downstream `ready_i`. The block also frames the stream into fixed-length packets (`sop_o`/`eop_o`) and counts completed packets.

## Interface
Parameters:
- `DWIDTH`, 32, data word width; must match the FIFO
- `PKT_LEN`, 8, words per packet; range 1..65535
- `CNT_W`, 16, width of `pkt_cnt_o`

Ports:
- `clk_i`  in  1  single clock; all logic on rising edge
- `srst_i`  in  1  synchronous reset, active-low; one clock, reset synchronous and active-low
- `en_i`  in  1  enables new FIFO pops; buffered words still drain when low
- `fifo_q_i`  in  DWIDTH  FIFO head word (show-ahead); valid whenever `fifo_empty_i`=0
- `fifo_empty_i`  in  1  FIFO empty flag
- `fifo_rdreq_o`  out  1  FIFO pop request; head word is consumed on the same edge
- `data_o`  out  DWIDTH  stream data (registered)
- `valid_o`  out  1  stream valid
- `ready_i`  in  1  stream ready; a beat transfers when `valid_o` & `ready_i`
- `sop_o`  out  1  first beat of a packet (qualified by `valid_o`)
- `eop_o`  out  1  last beat of a packet (qualified by `valid_o`)
- `pkt_cnt_o`  out  CNT_W  completed packets; wraps modulo 2^CNT_W

## Operation
- Buffer `occ` ∈ {0,1,2}. Head entry drives `data_o`. `valid_o` = (occ≠0).
- `fifo_rdreq_o` = `srst_i` & `en_i` & !`fifo_empty_i` & (occ<2). It is driven from registered state and FIFO flags only.
- push = `fifo_rdreq_o`; `fifo_q_i` is captured on that edge. pop = `valid_o` & `ready_i`.
- occ update:
  - push & !pop → occ+1
  - pop & !push → occ−1
  - both → unchanged
- Entry ordering:
  - occ=1, push & pop: the new word becomes the head.
  - occ=2, pop: entry 1 moves to the head. `fifo_rdreq_o`=0 in this cycle.
- Beat counter `bcnt` has width clog2(PKT_LEN), minimum 1. It increments on pop and wraps from PKT_LEN−1 to 0.
- `sop_o` = `valid_o` & (bcnt==0).
- `eop_o` = `valid_o` & (bcnt==PKT_LEN−1). With PKT_LEN=1, `sop_o` and `eop_o` are both asserted on every beat.
- `pkt_cnt_o` increments on pop & `eop_o`.
- The block does not reorder, duplicate or drop words, except for words discarded by reset.

## Timing
- Reset (`srst_i`=0 at an edge):
  - occ=0, bcnt=0, `pkt_cnt_o`=0, `data_o`=0, `valid_o`=0.
  - `fifo_rdreq_o`=0, `sop_o`=0, `eop_o`=0 for the whole reset cycle.
- Reset mid-operation: buffered words are discarded and any partial packet is abandoned. The first beat after reset carries `sop_o`.
- Latency: with occ=0 and the FIFO non-empty with `en_i`=1, `fifo_rdreq_o` is asserted in cycle N and `valid_o`=1 with that word in cycle N+1.
- Throughput: one word per cycle sustained while `ready_i`=1 and the FIFO is non-empty (occ stays at 1).
- Backpressure:
  - While `valid_o` & !`ready_i`, the signals `data_o`, `sop_o` and `eop_o` hold stable.
  - At most 2 words are absorbed; after that `fifo_rdreq_o` deasserts.
- When `en_i` falls, `fifo_rdreq_o` drops in the same cycle. The buffer drains normally.
- When `fifo_empty_i`=1, no pop is issued regardless of occ.

## Structure
- Package `fifo_stream_pkg`:
  - `occ_t` (2-bit) occupancy typedef.
  - Localparam function for bcnt width, `bcnt_w(PKT_LEN)` = max(1, $clog2(PKT_LEN)).
- Sub-module `fifo_stream_skid`: the two-entry registered buffer.
  - Ports: push/data in, pop, head data/valid out, occ out.
  - Parameter `DWIDTH`.
- The top level holds the rdreq logic, beat counter and packet counter.

## Test plan
- Reset: hold `srst_i`=0 for 3 cycles with the FIFO non-empty → `fifo_rdreq_o`=0, `valid_o`=0, `pkt_cnt_o`=0 throughout.
- Streaming: load the FIFO with 16 words 0..15, PKT_LEN=8, `ready_i`=1 → 16 consecutive beats 0..15.
  - `sop_o` on words 0 and 8; `eop_o` on words 7 and 15.
  - `pkt_cnt_o`=2; first beat appears 1 cycle after the first rdreq.
- Backpressure: FIFO holds 5 words, `ready_i`=0 for 6 cycles → exactly 2 rdreqs.
  - `data_o`=word0 stable; then `ready_i`=1 → words 0..4 in order, none lost.
- Random `ready_i` (50%) and random FIFO writes, 1000 words, PKT_LEN=5 → scoreboard order matches.
  - `pkt_cnt_o`=200; `sop_o`/`eop_o` every 5th beat.
- `en_i`=0 after 3 pops → `fifo_rdreq_o` drops the same cycle, buffered words drain.
  - Re-enable → stream resumes at the next word, packet framing continues.
- Reset mid-packet after beat 3 (PKT_LEN=8) → `valid_o`=0 next cycle; the next beat carries `sop_o`=1.
